// File: rtl/packer_pkg.sv
// Shared types and helpers for the sample stream packer.
package packer_pkg;

  typedef enum logic {
    MODE_RAW = 1'b0,
    MODE_RLE = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic int unsigned lanes_per_word(input mode_e mode, input int unsigned data_w,
                                                 input int unsigned sample_w,
                                                 input int unsigned cnt_w);
    return (mode == MODE_RLE) ? data_w / (sample_w + cnt_w) : data_w / sample_w;
  endfunction

endpackage

// File: rtl/packer_word_fifo.sv
// Two-entry output FIFO of {address, word}; entry 0 is always the head.
module packer_word_fifo #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADX_W  = 27
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic [ADX_W-1:0]  push_adx_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_data_o,
  output logic [ADX_W-1:0]  head_adx_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] data_q [2];
  logic [DATA_W-1:0] data_d [2];
  logic [ADX_W-1:0]  adx_q  [2];
  logic [ADX_W-1:0]  adx_d  [2];
  logic [1:0]        count_q, count_d;
  logic              pop_c, push_c, wr_idx_c;

  // Pop shifts entry 1 down; a push lands behind whatever survives the pop.
  always_comb begin
    data_d   = data_q;
    adx_d    = adx_q;
    pop_c    = pop_i && (count_q != 2'd0);
    push_c   = push_i && ((count_q != 2'd2) || pop_c);
    wr_idx_c = 1'b0;
    if (pop_c) begin
      data_d[0] = data_q[1];
      adx_d[0]  = adx_q[1];
    end
    if (push_c) begin
      wr_idx_c         = (count_q - 2'(pop_c)) != 2'd0;
      data_d[wr_idx_c] = push_data_i;
      adx_d[wr_idx_c]  = push_adx_i;
    end
    count_d = count_q + 2'(push_c) - 2'(pop_c);
    if (clr_i) begin
      count_d = 2'd0;
      data_d  = '{default: '0};
      adx_d   = '{default: '0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '{default: '0};
      adx_q   <= '{default: '0};
      count_q <= 2'd0;
    end else begin
      data_q  <= data_d;
      adx_q   <= adx_d;
      count_q <= count_d;
    end
  end

  assign head_data_o = data_q[0];
  assign head_adx_o  = adx_q[0];
  assign full_o      = (count_q == 2'd2);
  assign empty_o     = (count_q == 2'd0);

endmodule

// File: rtl/sample_stream_packer.sv
// Packs raw or run-length encoded capture samples into memory words with
// page tracking, flush and overflow detection, feeding a 2-deep write FIFO.
module sample_stream_packer
  import packer_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned ADX_W      = 27,
  parameter int unsigned ADX_STEP   = 8,
  parameter int unsigned PAGE_WORDS = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          arm,
  input  logic                          rle_en,
  input  logic [ADX_W-1:0]              base_adx,
  input  logic                          sample_valid,
  input  logic [SAMPLE_W-1:0]           sample_data,
  input  logic                          flush,
  output logic [DATA_W-1:0]             wr_data,
  output logic [ADX_W-1:0]              wr_adx,
  output logic                          write_req,
  input  logic                          write_allowed,
  output logic                          page_full,
  output logic                          overflow,
  output logic                          busy,
  output logic [$clog2(PAGE_WORDS):0]   words_done
);

  localparam int unsigned ENT_RAW = SAMPLE_W;
  localparam int unsigned ENT_RLE = SAMPLE_W + CNT_W;
  localparam int unsigned L_RAW   = lanes_per_word(MODE_RAW, DATA_W, SAMPLE_W, CNT_W);
  localparam int unsigned L_RLE   = lanes_per_word(MODE_RLE, DATA_W, SAMPLE_W, CNT_W);
  localparam int unsigned LANE_W  = $clog2(L_RAW + 1);
  localparam int unsigned WD_W    = $clog2(PAGE_WORDS) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic                run_act_q, run_act_d;
  logic [SAMPLE_W-1:0] run_smp_q, run_smp_d;
  logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;
  logic [ADX_W-1:0]    next_adx_q, next_adx_d;
  logic [WD_W-1:0]     words_done_q, words_done_d;
  logic                page_full_q, page_full_d;
  logic                overflow_q, overflow_d;
  logic                busy_q, busy_d;

  logic                pop_c, ins_c, push_req_c, fifo_push_c, fifo_clr_c;
  logic [DATA_W-1:0]   entry_c, word_ins_c, push_word_c;
  int unsigned         lanes_c, shift_c;
  logic                fifo_full, fifo_empty;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    word_d       = word_q;
    lane_d       = lane_q;
    run_act_d    = run_act_q;
    run_smp_d    = run_smp_q;
    run_cnt_d    = run_cnt_q;
    next_adx_d   = next_adx_q;
    words_done_d = words_done_q;
    page_full_d  = page_full_q;
    overflow_d   = overflow_q;
    ins_c        = 1'b0;
    entry_c      = '0;
    word_ins_c   = '0;
    push_req_c   = 1'b0;
    push_word_c  = '0;
    fifo_push_c  = 1'b0;
    fifo_clr_c   = 1'b0;
    pop_c        = write_req && write_allowed;
    lanes_c      = (mode_q == MODE_RLE) ? L_RLE : L_RAW;
    shift_c      = 32'(lane_q) * ((mode_q == MODE_RLE) ? ENT_RLE : ENT_RAW);

    case (state_q)
      S_RUN: begin
        if (sample_valid) begin
          if (mode_q == MODE_RAW) begin
            ins_c   = 1'b1;
            entry_c = DATA_W'(sample_data);
          end else if (!run_act_q) begin
            run_act_d = 1'b1;
            run_smp_d = sample_data;
            run_cnt_d = CNT_W'(1);
          end else if ((sample_data == run_smp_q) && (run_cnt_q != CNT_MAX)) begin
            run_cnt_d = run_cnt_q + CNT_W'(1);
          end else begin
            ins_c     = 1'b1;
            entry_c   = DATA_W'({run_cnt_q, run_smp_q});
            run_smp_d = sample_data;
            run_cnt_d = CNT_W'(1);
          end
        end
        if (flush) state_d = S_FLUSH;
      end
      // Close any open run first; the padded partial word goes out on a later cycle.
      S_FLUSH: begin
        if (run_act_q) begin
          ins_c     = 1'b1;
          entry_c   = DATA_W'({run_cnt_q, run_smp_q});
          run_act_d = 1'b0;
        end else begin
          if (lane_q != '0) begin
            push_req_c  = 1'b1;
            push_word_c = word_q;
            word_d      = '0;
            lane_d      = '0;
          end
          state_d = S_DONE;
        end
      end
      default: ;
    endcase

    if (ins_c) begin
      word_ins_c = word_q | (entry_c << shift_c);
      if (32'(lane_q) == lanes_c - 1) begin
        push_req_c  = 1'b1;
        push_word_c = word_ins_c;
        word_d      = '0;
        lane_d      = '0;
      end else begin
        word_d = word_ins_c;
        lane_d = lane_q + LANE_W'(1);
      end
    end

    // A completed word with no FIFO slot is dropped without consuming an address.
    if (push_req_c) begin
      if (fifo_full && !pop_c) begin
        overflow_d = 1'b1;
      end else begin
        fifo_push_c = 1'b1;
        next_adx_d  = next_adx_q + ADX_W'(ADX_STEP);
      end
    end

    if (pop_c && !page_full_q) begin
      words_done_d = words_done_q + WD_W'(1);
      if (words_done_d == WD_W'(PAGE_WORDS)) begin
        page_full_d = 1'b1;
        state_d     = S_DONE;
      end
    end

    if (arm) begin
      state_d      = S_RUN;
      mode_d       = rle_en ? MODE_RLE : MODE_RAW;
      word_d       = '0;
      lane_d       = '0;
      run_act_d    = 1'b0;
      next_adx_d   = base_adx;
      words_done_d = '0;
      page_full_d  = 1'b0;
      overflow_d   = 1'b0;
      fifo_push_c  = 1'b0;
      fifo_clr_c   = 1'b1;
    end

    busy_d = (state_d == S_RUN) || (state_d == S_FLUSH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mode_q       <= MODE_RAW;
      word_q       <= '0;
      lane_q       <= '0;
      run_act_q    <= 1'b0;
      run_smp_q    <= '0;
      run_cnt_q    <= '0;
      next_adx_q   <= '0;
      words_done_q <= '0;
      page_full_q  <= 1'b0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      word_q       <= word_d;
      lane_q       <= lane_d;
      run_act_q    <= run_act_d;
      run_smp_q    <= run_smp_d;
      run_cnt_q    <= run_cnt_d;
      next_adx_q   <= next_adx_d;
      words_done_q <= words_done_d;
      page_full_q  <= page_full_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
    end
  end

  packer_word_fifo #(
    .DATA_W (DATA_W),
    .ADX_W  (ADX_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (fifo_clr_c),
    .push_i      (fifo_push_c),
    .push_data_i (push_word_c),
    .push_adx_i  (next_adx_q),
    .pop_i       (pop_c),
    .head_data_o (wr_data),
    .head_adx_o  (wr_adx),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign write_req  = !fifo_empty;
  assign page_full  = page_full_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;
  assign words_done = words_done_q;

endmodule

// File: tb/tb_sample_stream_packer.sv
// Self-checking bench: default-geometry packer (4-word page) plus a CNT_W=4 / 80-bit instance.
module tb_sample_stream_packer;

  localparam int unsigned SW = 16;
  localparam int unsigned DW = 128;
  localparam int unsigned AW = 27;

  logic          clk = 1'b0;
  logic          reset, arm, arm4, rle_en, sample_valid, flush, write_allowed;
  logic [AW-1:0] base_adx;
  logic [SW-1:0] sample_data;

  logic [DW-1:0] wr_data;
  logic [AW-1:0] wr_adx;
  logic          write_req, page_full, overflow, busy;
  logic [2:0]    words_done;

  logic [79:0]   wr_data4;
  logic [AW-1:0] wr_adx4;
  logic          write_req4, page_full4, overflow4, busy4;
  logic [10:0]   words_done4;

  typedef struct {
    logic [AW-1:0]  adx;
    logic [127:0]   data;
  } exp_t;

  typedef struct {
    logic [SW-1:0] data;
    logic          exp_req;
  } vec_t;

  exp_t exp_q[$];
  exp_t exp4_q[$];
  exp_t mon_e, mon_e4;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sample_stream_packer #(
    .SAMPLE_W(16), .CNT_W(16), .DATA_W(128), .ADX_W(27), .ADX_STEP(8), .PAGE_WORDS(4)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm), .rle_en(rle_en), .base_adx(base_adx),
    .sample_valid(sample_valid), .sample_data(sample_data), .flush(flush),
    .wr_data(wr_data), .wr_adx(wr_adx), .write_req(write_req), .write_allowed(write_allowed),
    .page_full(page_full), .overflow(overflow), .busy(busy), .words_done(words_done)
  );

  sample_stream_packer #(
    .SAMPLE_W(16), .CNT_W(4), .DATA_W(80), .ADX_W(27), .ADX_STEP(8), .PAGE_WORDS(1024)
  ) dut4 (
    .clk(clk), .reset(reset), .arm(arm4), .rle_en(rle_en), .base_adx(base_adx),
    .sample_valid(sample_valid), .sample_data(sample_data), .flush(flush),
    .wr_data(wr_data4), .wr_adx(wr_adx4), .write_req(write_req4), .write_allowed(write_allowed),
    .page_full(page_full4), .overflow(overflow4), .busy(busy4), .words_done(words_done4)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack_raw(input int unsigned start);
    logic [127:0] w = '0;
    for (int k = 0; k < 8; k++) w[k*16 +: 16] = 16'(start + 32'(k));
    return w;
  endfunction

  task automatic push_main(input logic [AW-1:0] adx, input logic [127:0] data);
    exp_t e;
    e.adx  = adx;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_d4(input logic [AW-1:0] adx, input logic [127:0] data);
    exp_t e;
    e.adx  = adx;
    e.data = data;
    exp4_q.push_back(e);
  endtask

  // Accepted words are compared against the scoreboard on the falling edge.
  always @(negedge clk) begin
    if (!reset && write_req && write_allowed) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got adx %0h data %0h, none expected", wr_adx, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("word_data", wr_data, mon_e.data);
        check("word_adx", 128'(wr_adx), 128'(mon_e.adx));
      end
    end
    if (!reset && write_req4 && write_allowed) begin
      if (exp4_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word4: got adx %0h data %0h, none expected", wr_adx4, wr_data4);
      end else begin
        mon_e4 = exp4_q.pop_front();
        check("word4_data", 128'(wr_data4), mon_e4.data);
        check("word4_adx", 128'(wr_adx4), 128'(mon_e4.adx));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_main(input logic rle, input logic [AW-1:0] base);
    arm = 1'b1; rle_en = rle; base_adx = base;
    tick();
    arm = 1'b0;
  endtask

  task automatic arm_d4(input logic rle, input logic [AW-1:0] base);
    arm4 = 1'b1; rle_en = rle; base_adx = base;
    tick();
    arm4 = 1'b0;
  endtask

  task automatic send(input logic [SW-1:0] d, input logic fl);
    sample_valid = 1'b1; sample_data = d; flush = fl;
    tick();
    sample_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    int pend;
    pend = exp_q.size() + exp4_q.size() + int'(write_req) + int'(write_req4);
    while (pend != 0 && n < budget) begin
      tick();
      n++;
      pend = exp_q.size() + exp4_q.size() + int'(write_req) + int'(write_req4);
    end
    check(name, 128'(pend), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    vec_t t1[16];
    logic [127:0] held;
    int n;

    for (int i = 0; i < 16; i++) begin
      t1[i].data    = SW'(i + 1);
      t1[i].exp_req = (i == 7) || (i == 15);
    end

    reset = 1'b1; arm = 1'b0; arm4 = 1'b0; rle_en = 1'b0; base_adx = '0;
    sample_valid = 1'b0; sample_data = '0; flush = 1'b0; write_allowed = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_write_req", 128'(write_req), 128'd0);
    check("rst_wr_data", wr_data, 128'd0);
    check("rst_wr_adx", 128'(wr_adx), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_words_done", 128'(words_done), 128'd0);
    check("rst_flags", 128'({page_full, overflow}), 128'd0);
    reset = 1'b0;
    tick();

    // Raw packing, one sample per clock, write_req one clock after the last lane.
    push_main(27'd0, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    push_main(27'd8, 128'h0010_000f_000e_000d_000c_000b_000a_0009);
    arm_main(1'b0, 27'd0);
    check("t1_busy", 128'(busy), 128'd1);
    for (int i = 0; i < 16; i++) begin
      sample_valid = 1'b1;
      sample_data  = t1[i].data;
      tick();
      check("t1_write_req", 128'(write_req), 128'(t1[i].exp_req));
    end
    sample_valid = 1'b0;
    wait_idle("t1_drain", 20);

    // RLE with flush arriving alongside the last sample.
    push_main(27'h1000, {64'h0, 16'd3, 16'h5555, 16'd5, 16'hAAAA});
    arm_main(1'b1, 27'h1000);
    repeat (5) send(16'hAAAA, 1'b0);
    repeat (2) send(16'h5555, 1'b0);
    send(16'h5555, 1'b1);
    n = 0;
    while (busy && n < 10) begin tick(); n++; end
    check("t2_busy_drop", 128'(busy), 128'd0);
    wait_idle("t2_drain", 20);
    check("t2_words_done", 128'(words_done), 128'd1);

    // Run length saturates at 15 for CNT_W=4; main DUT is in DONE and must ignore this.
    push_d4(27'd0, 128'h51234_F1234);
    arm_d4(1'b1, 27'd0);
    repeat (20) send(16'h1234, 1'b0);
    pulse_flush();
    wait_idle("t3_drain", 20);
    check("t3_busy4", 128'(busy4), 128'd0);
    check("t3_words_done4", 128'(words_done4), 128'd1);
    check("t3_flags4", 128'({page_full4, overflow4}), 128'd0);
    check("t3_main_idle", 128'({write_req, words_done}), 128'({1'b0, 3'd1}));

    // Memory stalled: two words queue, the rest are dropped.
    write_allowed = 1'b0;
    push_main(27'h100, pack_raw(1));
    push_main(27'h108, pack_raw(9));
    arm_main(1'b0, 27'h100);
    for (int i = 1; i <= 32; i++) send(SW'(i), 1'b0);
    held = wr_data;
    repeat (3) tick();
    check("t4_overflow", 128'(overflow), 128'd1);
    check("t4_write_req", 128'(write_req), 128'd1);
    check("t4_head_stable", wr_data, held);
    check("t4_head_data", wr_data, pack_raw(1));
    check("t4_head_adx", 128'(wr_adx), 128'h100);
    write_allowed = 1'b1;
    wait_idle("t4_drain", 20);
    check("t4_words_done", 128'(words_done), 128'd2);
    pulse_flush();
    repeat (4) tick();
    check("t4_empty_flush", 128'({busy, write_req}), 128'd0);

    // Page of four words, later samples ignored, then re-arm.
    for (int k = 0; k < 4; k++) push_main(AW'(32'h40 + 32'(k) * 8), pack_raw(32'(k) * 8 + 1));
    arm_main(1'b0, 27'h40);
    for (int i = 1; i <= 48; i++) send(SW'(i), 1'b0);
    check("t5_page_full", 128'(page_full), 128'd1);
    check("t5_words_done", 128'(words_done), 128'd4);
    check("t5_busy", 128'(busy), 128'd0);
    wait_idle("t5_drain", 20);
    arm_main(1'b0, 27'h200);
    check("t5_rearm_flags", 128'({page_full, overflow, words_done}), 128'd0);
    push_main(27'h200, pack_raw(32'h101));
    for (int i = 0; i < 8; i++) send(SW'(32'h101 + 32'(i)), 1'b0);
    wait_idle("t5_rearm_drain", 20);

    // Reset mid-word with a queued word, then address wrap.
    write_allowed = 1'b0;
    arm_main(1'b0, 27'd0);
    for (int i = 1; i <= 11; i++) send(SW'(i), 1'b0);
    check("t6_pre_req", 128'(write_req), 128'd1);
    reset = 1'b1;
    tick();
    check("t6_rst_outputs", 128'({write_req, busy, page_full, overflow, words_done}), 128'd0);
    check("t6_rst_data", wr_data, 128'd0);
    check("t6_rst_adx", 128'(wr_adx), 128'd0);
    check("t6_rst_d4", 128'({write_req4, busy4, words_done4}), 128'd0);
    reset = 1'b0;
    write_allowed = 1'b1;
    tick();
    push_main(27'h7FF_FFF8, pack_raw(32'h21));
    push_main(27'd0, pack_raw(32'h29));
    arm_main(1'b0, 27'h7FF_FFF8);
    for (int i = 0; i < 16; i++) send(SW'(32'h21 + 32'(i)), 1'b0);
    wait_idle("t6_wrap_drain", 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
